// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: pops bytes from ps2_keyboard and emits registered key events.
// Optional ASCII translation is built only when PS2_ASCII_LUT_EN is defined.
module ps2_scancode_decoder #(
    parameter int KEY_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [7:0]           data,
    input  logic                 ready,
    input  logic                 overflow,
    output logic                 nextdata_n,
    output logic                 key_valid,
    output logic [7:0]           key_code,
    output logic                 key_ext,
    output logic                 key_release,
    output logic                 key_repeat,
    output logic                 mod_shift,
    output logic                 mod_ctrl,
    output logic                 mod_caps,
    output logic [7:0]           ascii,
    output logic [KEY_CNT_W-1:0] key_count,
    output logic [7:0]           err_cnt,
    output logic                 ovf_seen
);

    typedef enum logic {ST_ACCEPT, ST_DECODE} rx_state_t;
    typedef enum logic [2:0] {PF_NONE, PF_E0, PF_F0, PF_E0F0, PF_PAUSE} prefix_t;

    rx_state_t              state_q, state_d;
    prefix_t                prefix_q, prefix_d;
    logic [7:0]             byte_q, byte_d;
    logic [2:0]             skip_q, skip_d;
    logic                   hold_valid_q, hold_valid_d;
    logic                   hold_ext_q, hold_ext_d;
    logic [7:0]             hold_code_q, hold_code_d;
    logic                   key_valid_q, key_valid_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   key_ext_q, key_ext_d;
    logic                   key_release_q, key_release_d;
    logic                   key_repeat_q, key_repeat_d;
    logic                   shift_l_q, shift_l_d;
    logic                   shift_r_q, shift_r_d;
    logic                   ctrl_l_q, ctrl_l_d;
    logic                   ctrl_r_q, ctrl_r_d;
    logic                   caps_q, caps_d;
    logic [KEY_CNT_W-1:0]   key_count_q, key_count_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   ovf_seen_q, ovf_seen_d;

    logic                   emit;
    logic [7:0]             ev_code;
    logic                   ev_ext;
    logic                   ev_rel;
    logic                   ev_rep;
    logic                   err_inc;

`ifdef PS2_ASCII_LUT_EN
    logic [7:0]             ascii_q, ascii_d;
    logic [7:0]             lut_val;

    function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
            8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
            8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
            8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
            8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
            8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
            8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
            8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
            8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction
`endif

    assign nextdata_n = ~((state_q == ST_ACCEPT) & ready & clrn);

    always_comb begin
        state_d       = state_q;
        prefix_d      = prefix_q;
        byte_d        = byte_q;
        skip_d        = skip_q;
        hold_valid_d  = hold_valid_q;
        hold_ext_d    = hold_ext_q;
        hold_code_d   = hold_code_q;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_release_d = key_release_q;
        key_repeat_d  = key_repeat_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        ctrl_l_d      = ctrl_l_q;
        ctrl_r_d      = ctrl_r_q;
        caps_d        = caps_q;
        key_count_d   = key_count_q;
        err_cnt_d     = err_cnt_q;
        ovf_seen_d    = ovf_seen_q | overflow;
        emit          = 1'b0;
        ev_code       = byte_q;
        ev_ext        = (prefix_q == PF_E0) || (prefix_q == PF_E0F0);
        ev_rel        = (prefix_q == PF_F0) || (prefix_q == PF_E0F0);
        ev_rep        = 1'b0;
        err_inc       = 1'b0;
`ifdef PS2_ASCII_LUT_EN
        ascii_d       = ascii_q;
        lut_val       = 8'h00;
`endif

        if (state_q == ST_ACCEPT) begin
            if (ready) begin
                byte_d  = data;
                state_d = ST_DECODE;
            end
        end else begin
            state_d = ST_ACCEPT;
            if (prefix_q == PF_PAUSE) begin
                // The 7 bytes after E1 are swallowed; the last one releases a single Pause event.
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    emit     = 1'b1;
                    ev_code  = 8'hE1;
                    ev_ext   = 1'b0;
                    ev_rel   = 1'b0;
                    prefix_d = PF_NONE;
                end
            end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
                err_inc  = 1'b1;
                prefix_d = PF_NONE;
            end else if (byte_q == 8'hE0) begin
                if (prefix_q == PF_F0 || prefix_q == PF_E0F0)
                    err_inc = 1'b1;
                prefix_d = PF_E0;
            end else if (byte_q == 8'hF0) begin
                if (prefix_q == PF_NONE)
                    prefix_d = PF_F0;
                else if (prefix_q == PF_E0)
                    prefix_d = PF_E0F0;
            end else if (byte_q == 8'hE1 && prefix_q == PF_NONE) begin
                prefix_d = PF_PAUSE;
                skip_d   = 3'd7;
            end else if ((byte_q == 8'hAA || byte_q == 8'hFA) && prefix_q == PF_NONE) begin
                prefix_d = PF_NONE;
            end else begin
                emit     = 1'b1;
                prefix_d = PF_NONE;
            end
        end

        if (err_inc && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;

        if (emit) begin
            ev_rep        = !ev_rel && hold_valid_q &&
                            (hold_ext_q == ev_ext) && (hold_code_q == ev_code);
            key_valid_d   = 1'b1;
            key_code_d    = ev_code;
            key_ext_d     = ev_ext;
            key_release_d = ev_rel;
            key_repeat_d  = ev_rep;
            if (!ev_rel && !ev_rep) begin
                hold_valid_d = 1'b1;
                hold_ext_d   = ev_ext;
                hold_code_d  = ev_code;
                key_count_d  = key_count_q + KEY_CNT_W'(1);
            end else if (ev_rel && hold_valid_q &&
                         (hold_ext_q == ev_ext) && (hold_code_q == ev_code)) begin
                hold_valid_d = 1'b0;
            end
            if (ev_code == 8'h12 && !ev_ext) shift_l_d = !ev_rel;
            if (ev_code == 8'h59 && !ev_ext) shift_r_d = !ev_rel;
            if (ev_code == 8'h14 && !ev_ext) ctrl_l_d  = !ev_rel;
            if (ev_code == 8'h14 &&  ev_ext) ctrl_r_d  = !ev_rel;
            if (ev_code == 8'h58 && !ev_ext && !ev_rel && !ev_rep)
                caps_d = !caps_q;
`ifdef PS2_ASCII_LUT_EN
            // Case decision uses modifier state from before this event.
            if (!ev_ext && !ev_rel) begin
                lut_val = set2_to_ascii(ev_code);
                if (lut_val >= 8'h61 && lut_val <= 8'h7A &&
                    ((shift_l_q | shift_r_q) ^ caps_q))
                    lut_val = lut_val - 8'h20;
            end
            ascii_d = lut_val;
`endif
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_ACCEPT;
            prefix_q      <= PF_NONE;
            byte_q        <= 8'h00;
            skip_q        <= 3'd0;
            hold_valid_q  <= 1'b0;
            hold_ext_q    <= 1'b0;
            hold_code_q   <= 8'h00;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            shift_l_q     <= 1'b0;
            shift_r_q     <= 1'b0;
            ctrl_l_q      <= 1'b0;
            ctrl_r_q      <= 1'b0;
            caps_q        <= 1'b0;
            key_count_q   <= '0;
            err_cnt_q     <= 8'h00;
            ovf_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prefix_q      <= prefix_d;
            byte_q        <= byte_d;
            skip_q        <= skip_d;
            hold_valid_q  <= hold_valid_d;
            hold_ext_q    <= hold_ext_d;
            hold_code_q   <= hold_code_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_release_q <= key_release_d;
            key_repeat_q  <= key_repeat_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            ctrl_l_q      <= ctrl_l_d;
            ctrl_r_q      <= ctrl_r_d;
            caps_q        <= caps_d;
            key_count_q   <= key_count_d;
            err_cnt_q     <= err_cnt_d;
            ovf_seen_q    <= ovf_seen_d;
        end
    end

`ifdef PS2_ASCII_LUT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) ascii_q <= 8'h00;
        else       ascii_q <= ascii_d;
    end
    assign ascii = ascii_q;
`else
    assign ascii = 8'h00;
`endif

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign key_repeat  = key_repeat_q;
    assign mod_shift   = shift_l_q | shift_r_q;
    assign mod_ctrl    = ctrl_l_q | ctrl_r_q;
    assign mod_caps    = caps_q;
    assign key_count   = key_count_q;
    assign err_cnt     = err_cnt_q;
    assign ovf_seen    = ovf_seen_q;

endmodule
